lsu_mem_initiator: RTL
======================

LSU_MEM_INITIATOR -- requirements
Module: lsu_mem_initiator

Interface
REQ-001 Parameter DEPTH, default 4096, memory depth in words; ADDRWIDTH = clog2(DEPTH).
REQ-002 Parameter XLEN, default 32, data and core-address width.
REQ-003 Parameter TIMEOUT, default 8, max cycles waiting for mem_outEn after a read issue.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  core presents a load/store request.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  XLEN  core address.
REQ-010 req_wdata  input  XLEN  store data, right-aligned.
REQ-011 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core consumes response.
REQ-014 resp_rdata  output  XLEN  load result, already extended; 0 for stores and errors.
REQ-015 resp_err  output  1  request rejected or timed out.
REQ-016 mem_addr  output  ADDRWIDTH  memory address, req_addr[ADDRWIDTH-1:0].
REQ-017 mem_wrData  output  XLEN  store data.
REQ-018 mem_wrEn / mem_rdEn  output  1 each  write/read strobes.
REQ-019 mem_byteEn / mem_halfEn / mem_wordEn / mem_unsignedEn  output  1 each  access size and sign qualifiers.
REQ-020 mem_dataOut  input  XLEN  read data from memory controller.
REQ-021 mem_outEn  input  1  read data valid strobe.

Function
REQ-022 FSM states IDLE, ISSUE, RD_WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: on req_valid, latch request and check it; legal -> ISSUE, illegal -> RESP with resp_err=1, no memory strobe.
REQ-024 Illegal: load funct3 011/110/111; store funct3 other than 000/001/010; H not 2-byte aligned (addr[0]); W not 4-byte aligned (addr[1:0]); req_addr[XLEN-1:ADDRWIDTH] nonzero.
REQ-025 ISSUE lasts exactly one cycle: mem_wrEn or mem_rdEn =1 with mem_addr, mem_wrData and exactly one of byteEn/halfEn/wordEn driven from latched request; mem_unsignedEn=1 only for BU/HU.
REQ-026 Outside ISSUE, all mem_* strobes and qualifiers SHALL be 0; mem_addr/mem_wrData hold last value.
REQ-027 ISSUE store -> RESP next cycle, resp_rdata=0, resp_err=0.
REQ-028 ISSUE load -> RD_WAIT; wait counter cleared on entry.
REQ-029 RD_WAIT: mem_outEn=1 -> capture mem_dataOut into resp_rdata unmodified (controller performs extension), -> RESP, resp_err=0.
REQ-030 Nominal load latency: mem_rdEn cycle N, mem_outEn cycle N+2, resp_valid cycle N+3.
REQ-031 RD_WAIT: counter reaches TIMEOUT without mem_outEn -> RESP with resp_err=1, resp_rdata=0.
REQ-032 mem_outEn while not in RD_WAIT SHALL be ignored.
REQ-033 RESP: resp_valid=1, outputs stable until resp_ready=1; on resp_valid&resp_ready -> IDLE next cycle.
REQ-034 Back-to-back: minimum 3 cycles between accepted stores (IDLE, ISSUE, RESP).

Reset
REQ-035 rst=1 at a rising edge SHALL force IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, all mem strobes/qualifiers 0, mem_addr=0, mem_wrData=0, counter 0.
REQ-036 Reset in RD_WAIT or RESP SHALL abandon the transaction; a late mem_outEn after reset SHALL be ignored.

Verification
REQ-037 Store SW addr 0x10 data 0xDEADBEEF -> one cycle mem_wrEn=1, mem_wordEn=1, mem_addr=0x10; resp_valid next cycle, resp_err=0.
REQ-038 Load LB addr 0x10, model returns 0xFFFFFF80 with mem_outEn at issue+2 -> resp_rdata=0xFFFFFF80 at issue+3, mem_byteEn=1, mem_unsignedEn=0.
REQ-039 LH addr 0x11 -> resp_err=1, no mem_rdEn ever asserted; SW addr 0x1000 with DEPTH 4096 -> resp_err=1.
REQ-040 Load with model never asserting mem_outEn -> resp_err=1, resp_rdata=0 after TIMEOUT=8 wait cycles.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata stay constant, req_ready=0 throughout; new req_valid not accepted.
REQ-042 rst asserted in RD_WAIT, mem_outEn pulsed 1 cycle later -> state IDLE, resp_valid remains 0.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator_if
// Bundles the core-side request/response handshake and the memory-controller
// strobe/data bus used by lsu_mem_initiator.
//   master : the initiator (drives req_ready, resp_*, mem_* strobes/data)
//   slave  : the environment (core + memory controller)
// Parameters: XLEN (data/core address width), ADDRWIDTH (memory address width)
// ---------------------------------------------------------------------------
interface lsu_mem_initiator_if #(
    parameter int XLEN      = 32,
    parameter int ADDRWIDTH = 12
);
    // core request
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_wdata;
    logic [2:0]           req_funct3;
    // core response
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      resp_rdata;
    logic                 resp_err;
    // memory controller
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [XLEN-1:0]      mem_wrData;
    logic                 mem_wrEn;
    logic                 mem_rdEn;
    logic                 mem_byteEn;
    logic                 mem_halfEn;
    logic                 mem_wordEn;
    logic                 mem_unsignedEn;
    logic [XLEN-1:0]      mem_dataOut;
    logic                 mem_outEn;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  resp_ready,
        input  mem_dataOut, mem_outEn,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wrData, mem_wrEn, mem_rdEn,
        output mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        output resp_ready,
        output mem_dataOut, mem_outEn,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wrData, mem_wrEn, mem_rdEn,
        input  mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator
// Converts single RV32I load/store requests from a core into one-cycle memory
// controller strobes, waits (bounded by TIMEOUT) for read data, and returns a
// response with error indication for illegal or timed-out accesses.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_mem_initiator_if.master: req_* / resp_* core handshake and
//          mem_* memory controller strobes, qualifiers and data
// Parameters: DEPTH (memory words), XLEN (data width), TIMEOUT (read wait cap)
// ---------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int DEPTH   = 4096,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mem_initiator_if.master bus
);
    localparam int ADDRWIDTH = $clog2(DEPTH);
    localparam int CNTW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]           state;
    logic                 lat_we;
    logic [2:0]           lat_funct3;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      rdata_q;
    logic                 err_q;
    logic [CNTW-1:0]      wait_cnt;
    logic                 req_legal;
    logic [XLEN-1:0]      addr_high;
    logic                 issue;

    // Request legality: width code, natural alignment, address within memory.
    always_comb begin
        addr_high = bus.req_addr >> ADDRWIDTH;
        req_legal = 1'b1;
        if (bus.req_we) begin
            if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010}))
                req_legal = 1'b0;
        end else begin
            if (bus.req_funct3 inside {3'b011, 3'b110, 3'b111})
                req_legal = 1'b0;
        end
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            req_legal = 1'b0;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            req_legal = 1'b0;
        if (addr_high != '0)
            req_legal = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_funct3 <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we     <= bus.req_we;
                        lat_funct3 <= bus.req_funct3;
                        if (req_legal) begin
                            // mem_addr/mem_wrData only move on a legal access
                            // so they hold their last issued value otherwise.
                            addr_q  <= bus.req_addr[ADDRWIDTH-1:0];
                            wdata_q <= bus.req_wdata;
                            state   <= ISSUE;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Data strobe wins over timeout on the last wait cycle.
                    if (bus.mem_outEn) begin
                        rdata_q <= bus.mem_dataOut;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNTW'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign issue = (state == ISSUE);

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = err_q;

    assign bus.mem_addr       = addr_q;
    assign bus.mem_wrData     = wdata_q;
    assign bus.mem_wrEn       = issue &  lat_we;
    assign bus.mem_rdEn       = issue & ~lat_we;
    assign bus.mem_byteEn     = issue & (lat_funct3[1:0] == 2'b00);
    assign bus.mem_halfEn     = issue & (lat_funct3[1:0] == 2'b01);
    assign bus.mem_wordEn     = issue & (lat_funct3[1:0] == 2'b10);
    assign bus.mem_unsignedEn = issue &  lat_funct3[2];
endmodule
